// File: rtl/instr_issue_queue.sv
// instr_issue_queue: assembles byte-serial host stream (high byte first) into 16-bit words,
// buffers them in a DEPTH-entry FIFO and issues one word per cycle with a one-cycle strobe.
// Optional build macro NOP_SKIP_EN: drop assembled words with opcode 4'h0..4'h8.
module instr_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     flush,
    input  logic                     hold,
    output logic [15:0]              instr_out,
    output logic                     instr_ena,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic                     drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {WAIT_HI, WAIT_LO} state_t;

    state_t          state;
    logic [7:0]      hi_byte;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            accept;
    logic            wr_en;
    logic            pop;
    logic            keep;

`ifdef NOP_SKIP_EN
    assign keep = hi_byte[7:4] > 4'h8;
`else
    assign keep = 1'b1;
`endif

    // WAIT_LO never stalls: its FIFO slot was already guaranteed when the high byte was taken
    always_comb begin
        byte_ready = !flush && (state == WAIT_LO || fifo_count < FULL);
        accept     = byte_valid && byte_ready;
        wr_en      = accept && state == WAIT_LO && keep;
        pop        = fifo_count != '0 && !hold && !flush;
    end

    // FIFO storage carries no reset; validity is tracked by fifo_count
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {hi_byte, byte_in};
    end

    // assembler, FIFO pointers, registered issue stage and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_HI;
            hi_byte    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            instr_out  <= '0;
            instr_ena  <= 1'b0;
            issued_cnt <= '0;
            drop_err   <= 1'b0;
        end else if (flush) begin
            state      <= WAIT_HI;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            instr_out  <= '0;
            instr_ena  <= 1'b0;
            issued_cnt <= '0;
            drop_err   <= 1'b0;
        end else begin
            if (accept) state <= (state == WAIT_HI) ? WAIT_LO : WAIT_HI;
            if (accept && state == WAIT_HI) hi_byte <= byte_in;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + (AW+1)'(wr_en) - (AW+1)'(pop);
            instr_out  <= pop ? mem[rd_ptr] : 16'h0000;
            instr_ena  <= pop;
            if (pop) issued_cnt <= issued_cnt + CNT_W'(1);
            if (byte_valid && !byte_ready) drop_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: directed self-checking bench for instr_issue_queue (DEPTH=4, CNT_W=8).
module tb_instr_issue_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] instr_out;
    logic        instr_ena;
    logic [2:0]  fifo_count;
    logic [7:0]  issued_cnt;
    logic        drop_err;
    int checks = 0;
    int errors = 0;

    instr_issue_queue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .flush(flush), .hold(hold), .instr_out(instr_out),
        .instr_ena(instr_ena), .fifo_count(fifo_count), .issued_cnt(issued_cnt),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the following negedge after one posedge accepts the byte
    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic issue_chk(input string tag, input logic [15:0] w);
        check({tag, "_ena"}, 32'(instr_ena), 32'd1);
        check({tag, "_out"}, 32'(instr_out), 32'(w));
    endtask

    initial begin
        // reset
        #1 rst_n = 1'b0;
        #1;
        check("rst_out", 32'(instr_out), 32'h0);
        check("rst_ena", 32'(instr_ena), 32'h0);
        check("rst_cnt", 32'(fifo_count), 32'h0);
        check("rst_iss", 32'(issued_cnt), 32'h0);
        check("rst_drop", 32'(drop_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_ready", 32'(byte_ready), 32'h1);
        @(negedge clk);

        // T1 single word, two-edge latency after the low byte
        send_word(16'h935A);
        check("t1_cnt1", 32'(fifo_count), 32'd1);
        check("t1_nobypass", 32'(instr_ena), 32'd0);
        @(negedge clk);
        issue_chk("t1", 16'h935A);
        check("t1_iss", 32'(issued_cnt), 32'd1);
        check("t1_cnt0", 32'(fifo_count), 32'd0);
        @(negedge clk);
        check("t1_ena_drop", 32'(instr_ena), 32'd0);
        check("t1_out_zero", 32'(instr_out), 32'h0);

        // T2 fill under hold, drop on full, drain in order
        hold = 1'b1;
        send_word(16'h9111);
        send_word(16'hA222);
        send_word(16'hB333);
        send_word(16'hC444);
        check("t2_full", 32'(fifo_count), 32'd4);
        check("t2_noready", 32'(byte_ready), 32'd0);
        check("t2_ena_held", 32'(instr_ena), 32'd0);
        check("t2_drop0", 32'(drop_err), 32'd0);
        send_byte(8'hFF);
        check("t2_drop1", 32'(drop_err), 32'd1);
        check("t2_full2", 32'(fifo_count), 32'd4);
        hold = 1'b0;
        @(negedge clk);
        issue_chk("t2_w0", 16'h9111);
        @(negedge clk);
        issue_chk("t2_w1", 16'hA222);
        @(negedge clk);
        issue_chk("t2_w2", 16'hB333);
        @(negedge clk);
        issue_chk("t2_w3", 16'hC444);
        @(negedge clk);
        check("t2_idle", 32'(instr_ena), 32'd0);
        check("t2_iss", 32'(issued_cnt), 32'd5);
        check("t2_sticky", 32'(drop_err), 32'd1);

        // T3 simultaneous write and pop at count 2
        hold = 1'b1;
        send_word(16'hD001);
        send_word(16'hE002);
        check("t3_cnt2", 32'(fifo_count), 32'd2);
        send_byte(8'hF0);
        byte_in = 8'h03;
        byte_valid = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        byte_valid = 1'b0;
        check("t3_cnt_same", 32'(fifo_count), 32'd2);
        issue_chk("t3_w0", 16'hD001);
        @(negedge clk);
        issue_chk("t3_w1", 16'hE002);
        @(negedge clk);
        issue_chk("t3_w2", 16'hF003);
        check("t3_iss", 32'(issued_cnt), 32'd8);

        // T4 flush discards partial high byte and clears status
        send_byte(8'hA1);
        flush = 1'b1;
        #1 check("t4_ready_flush", 32'(byte_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("t4_cnt", 32'(fifo_count), 32'd0);
        check("t4_iss0", 32'(issued_cnt), 32'd0);
        check("t4_drop0", 32'(drop_err), 32'd0);
        send_word(16'h9107);
        @(negedge clk);
        issue_chk("t4", 16'h9107);
        check("t4_iss1", 32'(issued_cnt), 32'd1);

        // T5 zero-opcode word followed by a real word
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        send_word(16'h0000);
`ifdef NOP_SKIP_EN
        check("t5_cnt_skip", 32'(fifo_count), 32'd0);
        send_byte(8'h92);
        check("t5_no_nop", 32'(instr_ena), 32'd0);
`else
        check("t5_cnt", 32'(fifo_count), 32'd1);
        send_byte(8'h92);
        issue_chk("t5_nop", 16'h0000);
`endif
        send_byte(8'h03);
        check("t5_cnt1", 32'(fifo_count), 32'd1);
        @(negedge clk);
        issue_chk("t5_w", 16'h9203);
`ifdef NOP_SKIP_EN
        check("t5_iss", 32'(issued_cnt), 32'd1);
`else
        check("t5_iss", 32'(issued_cnt), 32'd2);
`endif

        // T6 asynchronous reset mid-stream with a partial word pending
        hold = 1'b1;
        send_word(16'h9A01);
        send_word(16'h9A02);
        send_word(16'h9A03);
        check("t6_cnt3", 32'(fifo_count), 32'd3);
        send_byte(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        check("t6_cnt", 32'(fifo_count), 32'd0);
        check("t6_iss", 32'(issued_cnt), 32'd0);
        check("t6_ena", 32'(instr_ena), 32'd0);
        check("t6_out", 32'(instr_out), 32'h0);
        check("t6_drop", 32'(drop_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        send_word(16'h9A0B);
        @(negedge clk);
        issue_chk("t6_after", 16'h9A0B);
        check("t6_iss1", 32'(issued_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
